// File: rtl/uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_if
// Pop-side bus between the receive FIFO and the APB register block.
//   rd_en    : pop request (register block -> FIFO)
//   rd_data  : head entry data, first-word-fall-through (FIFO -> register block)
//   rd_err   : head entry error bit
//   empty    : FIFO holds no entries
//   full     : FIFO holds DEPTH entries
//   count    : number of stored entries
// Modports: master = register block side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) ();

  logic                     rd_en;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     rd_err;
  logic                     empty;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output rd_en,
    input  rd_data, rd_err, empty, full, count
  );

  modport slave (
    input  rd_en,
    output rd_data, rd_err, empty, full, count
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side buffer behind uart_rx. Every completed frame {rx_error, rx_data}
// is captured once into a first-word-fall-through FIFO that the register block
// pops through rd_if. Reports sticky overrun, a level interrupt and, when
// built with UART_RXF_TIMEOUT_EN defined, a character-timeout interrupt.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   rx_data      : received byte from uart_rx
//   rx_ready     : frame complete (pulse or held level; rising edge = one write)
//   rx_error     : parity/stop error of the current frame
//   baud_en_16x  : oversample tick, used only by the timeout counter
//   rd_if        : pop bus (rd_en, rd_data, rd_err, empty, full, count)
//   overrun      : sticky, a frame was dropped because the FIFO was full
//   ovr_clr      : clears overrun (a same-cycle drop wins)
//   level_irq    : count >= THRESHOLD
//   timeout_irq  : no FIFO activity for TIMEOUT_TICKS ticks while not empty
//
// Optional feature macro: UART_RXF_TIMEOUT_EN (undefined -> timeout_irq = 0).
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int THRESHOLD     = 8,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_ready,
  input  logic                  rx_error,
  input  logic                  baud_en_16x,
  uart_rx_fifo_if.slave         rd_if,
  output logic                  overrun,
  input  logic                  ovr_clr,
  output logic                  level_irq,
  output logic                  timeout_irq
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};

  // Storage and state
  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               rx_ready_q_r;
  logic [ENTRY_W-1:0] head_r;
  logic               empty_r;
  logic               full_r;
  logic               overrun_r;
  logic               level_irq_r;

  // Next-state helpers
  logic               wr_strobe_s;
  logic               rd_accept_s;
  logic               wr_accept_s;
  logic               drop_s;
  logic [ENTRY_W-1:0] wr_entry_s;
  logic [PTR_W-1:0]   wr_ptr_next_s;
  logic [PTR_W-1:0]   rd_ptr_next_s;
  logic [CNT_W-1:0]   count_next_s;
  logic [ENTRY_W-1:0] head_next_s;

  // Write strobe, pop/write acceptance and next pointer/count values.
  // A pop frees a slot in the same cycle, so a write into a full FIFO that is
  // being popped is accepted and does not count as a drop.
  always_comb begin
    wr_strobe_s   = rx_ready & ~rx_ready_q_r;
    wr_entry_s    = {rx_error, rx_data};
    rd_accept_s   = rd_if.rd_en & (count_r != ZERO_C);
    wr_accept_s   = 1'b0;
    drop_s        = 1'b0;
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    count_next_s  = count_r;

    if (wr_strobe_s && ((count_r != DEPTH_C) || rd_accept_s)) begin
      wr_accept_s = 1'b1;
    end else if (wr_strobe_s) begin
      drop_s = 1'b1;
    end else begin
      wr_accept_s = 1'b0;
    end

    if (wr_accept_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end

    if (rd_accept_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end

    case ({wr_accept_s, rd_accept_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Next head value; bypasses the write data when the entry being written
  // becomes the head, and forces zero when the FIFO will be empty.
  always_comb begin
    head_next_s = {ENTRY_W{1'b0}};
    if (count_next_s == ZERO_C) begin
      head_next_s = {ENTRY_W{1'b0}};
    end else if (wr_accept_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = wr_entry_s;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Entry storage; no reset needed since entries are only read once written.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept_s) begin
      mem_r[wr_ptr_r] <= wr_entry_s;
    end
  end

  // Pointers, count, registered status flags and head output.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ready_q_r <= 1'b0;
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= ZERO_C;
      head_r       <= {ENTRY_W{1'b0}};
      empty_r      <= 1'b1;
      full_r       <= 1'b0;
      level_irq_r  <= 1'b0;
    end else begin
      rx_ready_q_r <= rx_ready;
      wr_ptr_r     <= wr_ptr_next_s;
      rd_ptr_r     <= rd_ptr_next_s;
      count_r      <= count_next_s;
      head_r       <= head_next_s;
      empty_r      <= (count_next_s == ZERO_C);
      full_r       <= (count_next_s == DEPTH_C);
      level_irq_r  <= (count_next_s >= THRESH_C);
    end
  end

  // Sticky overrun; a new drop takes priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end else if (ovr_clr) begin
      overrun_r <= 1'b0;
    end
  end

`ifdef UART_RXF_TIMEOUT_EN
  localparam int             TO_W     = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0] TICKS_C = TO_W'(TIMEOUT_TICKS);

  logic [TO_W-1:0] to_cnt_r;
  logic [TO_W-1:0] to_cnt_next_s;
  logic            timeout_irq_r;
  logic            timeout_irq_next_s;

  // Idle-tick counter: restarts on any accepted transfer or while empty,
  // saturates at TIMEOUT_TICKS; the irq holds until the next transfer.
  always_comb begin
    to_cnt_next_s      = to_cnt_r;
    timeout_irq_next_s = timeout_irq_r;
    if (wr_accept_s || rd_accept_s) begin
      to_cnt_next_s      = {TO_W{1'b0}};
      timeout_irq_next_s = 1'b0;
    end else if (count_r == ZERO_C) begin
      to_cnt_next_s      = {TO_W{1'b0}};
      timeout_irq_next_s = timeout_irq_r;
    end else if (baud_en_16x && (to_cnt_r != TICKS_C)) begin
      to_cnt_next_s      = to_cnt_r + TO_W'(1);
      timeout_irq_next_s = timeout_irq_r | (to_cnt_r + TO_W'(1) == TICKS_C);
    end else begin
      to_cnt_next_s      = to_cnt_r;
      timeout_irq_next_s = timeout_irq_r;
    end
  end

  // Timeout counter and irq registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_r      <= {TO_W{1'b0}};
      timeout_irq_r <= 1'b0;
    end else begin
      to_cnt_r      <= to_cnt_next_s;
      timeout_irq_r <= timeout_irq_next_s;
    end
  end

  assign timeout_irq = timeout_irq_r;
`else
  // Feature not built: the tick input and timeout length are not used.
  logic unused_timeout_s;
  assign unused_timeout_s = baud_en_16x | (TIMEOUT_TICKS < 1);
  assign timeout_irq      = 1'b0;
`endif

  assign rd_if.rd_data = head_r[DATA_WIDTH-1:0];
  assign rd_if.rd_err  = head_r[DATA_WIDTH];
  assign rd_if.empty   = empty_r;
  assign rd_if.full    = full_r;
  assign rd_if.count   = count_r;
  assign overrun       = overrun_r;
  assign level_irq     = level_irq_r;

endmodule
